// File: rtl/mips_pkg.sv
// Shared MIPS pipeline encodings (load types, write-back source selects) and width defaults.
package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;
    localparam int SEL_W_DEF  = 2;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [2:0] {
        LT_LW  = 3'd0,
        LT_LB  = 3'd1,
        LT_LBU = 3'd2,
        LT_LH  = 3'd3,
        LT_LHU = 3'd4
    } load_type_e;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'd0,
        WB_SEL_LOAD = 2'd1,
        WB_SEL_LINK = 2'd2,
        WB_SEL_HILO = 2'd3
    } wb_sel_e;

    function automatic logic is_half_load(input logic [2:0] lt);
        return (lt == LT_LH) || (lt == LT_LHU);
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational little-endian lane select and sign/zero extension of load data; flags odd halfword addresses.
module load_align
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] load_data_i,
    input  logic [1:0]        addr_low_i,
    input  logic [2:0]        load_type_i,
    output logic [DATA_W-1:0] aligned_o,
    output logic              misalign_o
);

    logic [31:0] word;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Only the low word is laned, so a 64-bit datapath behaves like a sign-extending LW.
    assign word      = load_data_i[31:0];
    assign byte_lane = word[{addr_low_i, 3'b000} +: 8];
    assign half_lane = word[{addr_low_i[1], 4'b0000} +: 16];

    always_comb begin
        aligned_o = DATA_W'($signed(word));
        case (load_type_i)
            LT_LB:   aligned_o = DATA_W'($signed(byte_lane));
            LT_LBU:  aligned_o = DATA_W'(byte_lane);
            LT_LH:   aligned_o = DATA_W'($signed(half_lane));
            LT_LHU:  aligned_o = DATA_W'(half_lane);
            default: aligned_o = DATA_W'($signed(word));
        endcase
    end

    assign misalign_o = is_half_load(load_type_i) && addr_low_i[0];

endmodule

// File: rtl/writeback_stage_pipe.sv
// MEM/WB register with load alignment, result select, write-port drive and retired-write counter.
// Optional one-deep committed-write history for ID forwarding when WB_HISTORY_EN is defined.
module writeback_stage_pipe
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int SEL_W  = SEL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Valid_MEM,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              RegWrite_MEM,
    input  logic [REG_AW-1:0] WriteReg_MEM,
    input  logic [SEL_W-1:0]  MemReg_MEM,
    input  logic [2:0]        LoadType_MEM,
    input  logic [1:0]        AddrLow_MEM,
    input  logic [DATA_W-1:0] ALUResult_MEM,
    input  logic [DATA_W-1:0] LoadData_MEM,
    input  logic [DATA_W-1:0] PCLink_MEM,
    input  logic [DATA_W-1:0] HiLo_MEM,
    output logic              RegWrite_WB,
    output logic [REG_AW-1:0] WriteReg_WB,
    output logic [DATA_W-1:0] WriteData_WB,
    output logic              Misalign_WB,
`ifdef WB_HISTORY_EN
    output logic              PrevWriteValid,
    output logic [REG_AW-1:0] PrevWriteReg,
    output logic [DATA_W-1:0] PrevWriteData,
`endif
    output logic [CNT_W-1:0]  RetireCnt
);

    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
        $error("writeback_stage_pipe: DATA_W must be 32 or 64");
    end

    logic [DATA_W-1:0] load_aligned;
    logic              load_misalign;
    logic [DATA_W-1:0] result_d;
    logic              capture;
    logic              misalign_d;
    logic              we_d;

    logic              regwrite_q;
    logic [REG_AW-1:0] wreg_q;
    logic [DATA_W-1:0] wdata_q;
    logic              misalign_q;
    logic [CNT_W-1:0]  cnt_q;

    load_align #(.DATA_W(DATA_W)) u_load_align (
        .load_data_i (LoadData_MEM),
        .addr_low_i  (AddrLow_MEM),
        .load_type_i (LoadType_MEM),
        .aligned_o   (load_aligned),
        .misalign_o  (load_misalign)
    );

    always_comb begin
        result_d = ALUResult_MEM;
        case (MemReg_MEM)
            SEL_W'(WB_SEL_LOAD): result_d = load_aligned;
            SEL_W'(WB_SEL_LINK): result_d = PCLink_MEM;
            SEL_W'(WB_SEL_HILO): result_d = HiLo_MEM;
            default:             result_d = ALUResult_MEM;
        endcase
    end

    // The misalign flag from the aligner only matters when the load result is actually selected.
    assign capture    = !Stall && Valid_MEM && !Flush;
    assign misalign_d = capture && (MemReg_MEM == SEL_W'(WB_SEL_LOAD)) && load_misalign;
    assign we_d       = capture && RegWrite_MEM && (WriteReg_MEM != '0) && !misalign_d;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else if (Stall) begin
            misalign_q <= 1'b0;
        end else begin
            regwrite_q <= we_d;
            misalign_q <= misalign_d;
            if (capture) begin
                wreg_q  <= WriteReg_MEM;
                wdata_q <= result_d;
            end
            if (we_d) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign RegWrite_WB  = regwrite_q;
    assign WriteReg_WB  = wreg_q;
    assign WriteData_WB = wdata_q;
    assign Misalign_WB  = misalign_q;
    assign RetireCnt    = cnt_q;

`ifdef WB_HISTORY_EN
    logic              last_vld_q;
    logic [REG_AW-1:0] last_reg_q;
    logic [DATA_W-1:0] last_dat_q;
    logic              prev_vld_q;
    logic [REG_AW-1:0] prev_reg_q;
    logic [DATA_W-1:0] prev_dat_q;

    // last_* tracks the newest commit even across bubbles; prev_* is the one before it.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            last_vld_q <= 1'b0;
            last_reg_q <= '0;
            last_dat_q <= '0;
            prev_vld_q <= 1'b0;
            prev_reg_q <= '0;
            prev_dat_q <= '0;
        end else if (we_d) begin
            last_vld_q <= 1'b1;
            last_reg_q <= WriteReg_MEM;
            last_dat_q <= result_d;
            prev_vld_q <= last_vld_q;
            prev_reg_q <= last_reg_q;
            prev_dat_q <= last_dat_q;
        end
    end

    assign PrevWriteValid = prev_vld_q;
    assign PrevWriteReg   = prev_reg_q;
    assign PrevWriteData  = prev_dat_q;
`endif

endmodule

// File: tb/tb_writeback_stage_pipe.sv
// Self-checking bench for writeback_stage_pipe: vector table, hand sequences, random vs reference model.
module tb_writeback_stage_pipe;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Valid_MEM, Stall, Flush, RegWrite_MEM;
    logic [4:0]  WriteReg_MEM;
    logic [1:0]  MemReg_MEM;
    logic [2:0]  LoadType_MEM;
    logic [1:0]  AddrLow_MEM;
    logic [31:0] ALUResult_MEM, LoadData_MEM, PCLink_MEM, HiLo_MEM;
    logic        RegWrite_WB;
    logic [4:0]  WriteReg_WB;
    logic [31:0] WriteData_WB;
    logic        Misalign_WB;
    logic [15:0] RetireCnt;

    writeback_stage_pipe dut (
        .Clk(Clk), .Rst(Rst), .Valid_MEM(Valid_MEM), .Stall(Stall), .Flush(Flush),
        .RegWrite_MEM(RegWrite_MEM), .WriteReg_MEM(WriteReg_MEM), .MemReg_MEM(MemReg_MEM),
        .LoadType_MEM(LoadType_MEM), .AddrLow_MEM(AddrLow_MEM), .ALUResult_MEM(ALUResult_MEM),
        .LoadData_MEM(LoadData_MEM), .PCLink_MEM(PCLink_MEM), .HiLo_MEM(HiLo_MEM),
        .RegWrite_WB(RegWrite_WB), .WriteReg_WB(WriteReg_WB), .WriteData_WB(WriteData_WB),
        .Misalign_WB(Misalign_WB), .RetireCnt(RetireCnt)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // Reference model state (what WB should show after the next edge)
    logic        m_rw, m_mis;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;
    int          m_cnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] ld, input logic [1:0] al,
                                             input logic [2:0] lt);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'((ld >> (8 * al)) & 32'hFF);
        h = 16'((ld >> (16 * (al / 2))) & 32'hFFFF);
        case (lt)
            3'd1:    return {{24{b[7]}}, b};
            3'd2:    return {24'h0, b};
            3'd3:    return {{16{h[15]}}, h};
            3'd4:    return {16'h0, h};
            default: return ld;
        endcase
    endfunction

    task automatic model_reset();
        m_rw = 0; m_mis = 0; m_wr = 0; m_wd = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        logic [31:0] res;
        logic        mis;
        if (Stall) begin
            m_mis = 0;
        end else if (Flush || !Valid_MEM) begin
            m_rw  = 0;
            m_mis = 0;
        end else begin
            case (MemReg_MEM)
                2'd0: res = ALUResult_MEM;
                2'd1: res = ref_load(LoadData_MEM, AddrLow_MEM, LoadType_MEM);
                2'd2: res = PCLink_MEM;
                default: res = HiLo_MEM;
            endcase
            mis   = (MemReg_MEM == 2'd1) && (LoadType_MEM == 3'd3 || LoadType_MEM == 3'd4)
                    && (AddrLow_MEM % 2 == 1);
            m_rw  = RegWrite_MEM && (WriteReg_MEM != 0) && !mis;
            m_mis = mis;
            m_wr  = WriteReg_MEM;
            m_wd  = res;
            if (m_rw) m_cnt = (m_cnt + 1) % 65536;
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".rw"},  RegWrite_WB,  m_rw);
        chk({tag, ".wr"},  WriteReg_WB,  m_wr);
        chk({tag, ".wd"},  WriteData_WB, m_wd);
        chk({tag, ".mis"}, Misalign_WB,  m_mis);
        chk({tag, ".cnt"}, RetireCnt,    m_cnt[15:0]);
    endtask

    task automatic drive(input logic v, input logic st, input logic fl, input logic rw,
                         input logic [4:0] wr, input logic [1:0] sel, input logic [2:0] lt,
                         input logic [1:0] al, input logic [31:0] src);
        Valid_MEM = v; Stall = st; Flush = fl; RegWrite_MEM = rw; WriteReg_MEM = wr;
        MemReg_MEM = sel; LoadType_MEM = lt; AddrLow_MEM = al;
        ALUResult_MEM = (sel == 2'd0) ? src : $urandom;
        LoadData_MEM  = (sel == 2'd1) ? src : $urandom;
        PCLink_MEM    = (sel == 2'd2) ? src : $urandom;
        HiLo_MEM      = (sel == 2'd3) ? src : $urandom;
    endtask

    typedef struct {
        logic [2:0]  lt;
        logic [1:0]  al;
        logic [1:0]  sel;
        logic [4:0]  wr;
        logic [31:0] src;
        logic        exp_rw;
        logic [31:0] exp_wd;
        logic        exp_mis;
        logic        chk_wd;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int cnt_before;

        tbl = '{
            '{3'd1, 2'd1, 2'd1, 5'd8,  32'h1234_80FF, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b1},
            '{3'd2, 2'd1, 2'd1, 5'd8,  32'h1234_80FF, 1'b1, 32'h0000_0080, 1'b0, 1'b1},
            '{3'd3, 2'd2, 2'd1, 5'd9,  32'h8001_0000, 1'b1, 32'hFFFF_8001, 1'b0, 1'b1},
            '{3'd4, 2'd3, 2'd1, 5'd9,  32'h8001_0000, 1'b0, 32'h0,         1'b1, 1'b0},
            '{3'd0, 2'd0, 2'd2, 5'd31, 32'h0040_0008, 1'b1, 32'h0040_0008, 1'b0, 1'b1},
            '{3'd0, 2'd0, 2'd2, 5'd0,  32'h0040_0008, 1'b0, 32'h0040_0008, 1'b0, 1'b1},
            '{3'd0, 2'd2, 2'd0, 5'd5,  32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1},
            '{3'd1, 2'd1, 2'd3, 5'd6,  32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1},
            '{3'd6, 2'd2, 2'd1, 5'd7,  32'h8765_4321, 1'b1, 32'h8765_4321, 1'b0, 1'b1},
            '{3'd3, 2'd1, 2'd1, 5'd7,  32'h1234_5678, 1'b0, 32'h0,         1'b1, 1'b0},
            '{3'd1, 2'd3, 2'd1, 5'd10, 32'h7F00_0000, 1'b1, 32'h0000_007F, 1'b0, 1'b1},
            '{3'd3, 2'd0, 2'd1, 5'd11, 32'h0000_8000, 1'b1, 32'hFFFF_8000, 1'b0, 1'b1}
        };

        // Reset state
        Rst = 1'b1;
        drive(0, 0, 0, 0, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0);
        model_reset();
        #12;
        Rst = 1'b0;
        chk("reset.rw",  RegWrite_WB,  1'b0);
        chk("reset.wr",  WriteReg_WB,  5'd0);
        chk("reset.wd",  WriteData_WB, 32'h0);
        chk("reset.mis", Misalign_WB,  1'b0);
        chk("reset.cnt", RetireCnt,    16'h0);

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            cnt_before = m_cnt;
            drive(1, 0, 0, 1, tbl[i].wr, tbl[i].sel, tbl[i].lt, tbl[i].al, tbl[i].src);
            cycle();
            chk($sformatf("vec%0d.rw", i),  RegWrite_WB, tbl[i].exp_rw);
            chk($sformatf("vec%0d.mis", i), Misalign_WB, tbl[i].exp_mis);
            chk($sformatf("vec%0d.wr", i),  WriteReg_WB, tbl[i].wr);
            chk($sformatf("vec%0d.cnt", i), RetireCnt, 16'(cnt_before + int'(tbl[i].exp_rw)));
            if (tbl[i].chk_wd) chk($sformatf("vec%0d.wd", i), WriteData_WB, tbl[i].exp_wd);
        end

        // Stall held three cycles, then a flushed instruction
        drive(1, 0, 0, 1, 5'd12, 2'd0, 3'd0, 2'd0, 32'h1111_1111);
        cycle();
        cnt_before = m_cnt;
        chk("stall.pre.rw", RegWrite_WB, 1'b1);
        chk("stall.pre.wd", WriteData_WB, 32'h1111_1111);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 1, 5'd13, 2'd0, 3'd0, 2'd0, 32'h2222_2222);
            cycle();
            chk($sformatf("stall%0d.rw", i),  RegWrite_WB,  1'b1);
            chk($sformatf("stall%0d.wr", i),  WriteReg_WB,  5'd12);
            chk($sformatf("stall%0d.wd", i),  WriteData_WB, 32'h1111_1111);
            chk($sformatf("stall%0d.cnt", i), RetireCnt,    16'(cnt_before));
        end
        drive(1, 0, 1, 1, 5'd14, 2'd0, 3'd0, 2'd0, 32'h3333_3333);
        cycle();
        chk("flush.rw",  RegWrite_WB,  1'b0);
        chk("flush.wr",  WriteReg_WB,  5'd12);
        chk("flush.wd",  WriteData_WB, 32'h1111_1111);
        chk("flush.cnt", RetireCnt,    16'(cnt_before));

        // Misalign pulse cleared by a following stall
        drive(1, 0, 0, 1, 5'd15, 2'd1, 3'd4, 2'd1, 32'hAAAA_5555);
        cycle();
        chk("misst.mis0", Misalign_WB, 1'b1);
        chk("misst.rw0",  RegWrite_WB, 1'b0);
        drive(1, 1, 0, 1, 5'd16, 2'd0, 3'd0, 2'd0, 32'h0);
        cycle();
        chk("misst.mis1", Misalign_WB, 1'b0);

        // Asynchronous reset mid-cycle while a write is showing
        drive(1, 0, 0, 1, 5'd20, 2'd0, 3'd0, 2'd0, 32'h5A5A_5A5A);
        cycle();
        chk("arst.pre.rw", RegWrite_WB, 1'b1);
        drive(0, 0, 0, 0, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0);
        #2;
        Rst = 1'b1;
        #1;
        chk("arst.rw",  RegWrite_WB,  1'b0);
        chk("arst.wr",  WriteReg_WB,  5'd0);
        chk("arst.wd",  WriteData_WB, 32'h0);
        chk("arst.mis", Misalign_WB,  1'b0);
        chk("arst.cnt", RetireCnt,    16'h0);
        #1;
        Rst = 1'b0;
        model_reset();
        @(posedge Clk);
        #1;

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            Valid_MEM     = ($urandom_range(0, 9) < 8);
            Stall         = ($urandom_range(0, 9) < 2);
            Flush         = ($urandom_range(0, 9) == 0);
            RegWrite_MEM  = ($urandom_range(0, 9) < 8);
            WriteReg_MEM  = 5'($urandom_range(0, 31));
            MemReg_MEM    = 2'($urandom_range(0, 3));
            LoadType_MEM  = 3'($urandom_range(0, 7));
            AddrLow_MEM   = 2'($urandom_range(0, 3));
            ALUResult_MEM = $urandom;
            LoadData_MEM  = $urandom;
            PCLink_MEM    = $urandom;
            HiLo_MEM      = $urandom;
            cycle();
            check_model($sformatf("rand%0d", i));
        end

        // Counter wrap: 65535 commits reach all-ones, one more wraps to zero
        Rst = 1'b1;
        drive(0, 0, 0, 0, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0);
        #2;
        Rst = 1'b0;
        model_reset();
        drive(1, 0, 0, 1, 5'd1, 2'd0, 3'd0, 2'd0, 32'h0000_0001);
        for (int i = 0; i < 65535; i++) cycle();
        chk("wrap.full", RetireCnt, 16'hFFFF);
        chk("wrap.full.model", RetireCnt, m_cnt[15:0]);
        cycle();
        chk("wrap.zero", RetireCnt, 16'h0000);
        chk("wrap.rw",   RegWrite_WB, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/writeback_stage_pipe.md
Name: writeback_stage_pipe

Overview:
- Parametrised successor to the combinational MIPS write-back select.
- Registers the MEM/WB boundary and aligns and extends sub-word loads.
- Selects one of four result sources and drives the register-file write port.
- Exposes the committed write for forwarding to EX/ID, with stall/flush control from the hazard unit.

Parameters:
- DATA_W, 32, datapath width; must be 32 or 64.
- REG_AW, 5, register-file address width.
- SEL_W, 2, result-select width; four sources.
- CNT_W, 16, width of the retired-write counter.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Valid_MEM  in  1  MEM stage presents a valid instruction this cycle.
- Stall  in  1  hold the MEM/WB register contents; no capture.
- Flush  in  1  kill the instruction being captured this cycle.
- RegWrite_MEM  in  1  instruction writes the register file.
- WriteReg_MEM  in  REG_AW  destination register.
- MemReg_MEM  in  SEL_W  result select: 0 ALU, 1 load, 2 PC+8 link, 3 HI/LO move.
- LoadType_MEM  in  3  load type: 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU; 5-7 reserved, treated as LW.
- AddrLow_MEM  in  2  effective address bits [1:0].
- ALUResult_MEM, LoadData_MEM, PCLink_MEM, HiLo_MEM  in  DATA_W each  candidate results.
- RegWrite_WB  out  1  register-file write enable.
- WriteReg_WB  out  REG_AW  register-file write address.
- WriteData_WB  out  DATA_W  register-file write data.
- Misalign_WB  out  1  one-cycle pulse: a halfword load had AddrLow[0]=1.
- RetireCnt  out  CNT_W  count of committed register writes.

Behaviour:
- Reset (asynchronous, immediate): RegWrite_WB=0, WriteReg_WB=0, WriteData_WB=0, Misalign_WB=0, RetireCnt=0. All MEM/WB pipeline state is cleared.
- Latency: one cycle. Inputs captured at edge N are visible on the WB outputs after edge N.
- Capture rules, in priority order:
  - Stall=1: hold all outputs, except Misalign_WB, which is forced to 0 after the first held cycle.
  - Otherwise, if Flush=1 or Valid_MEM=0: capture a bubble. RegWrite_WB=0, Misalign_WB=0; WriteReg_WB and WriteData_WB hold their previous values.
  - Otherwise: capture the instruction.
- Stall and Flush asserted together: Stall wins, and the flush is lost; the hazard unit must not assert both.
- Load alignment (combinational, before the register). AddrLow selects the lane, little-endian:
  - Byte lane = LoadData[8*AddrLow +: 8].
  - Halfword lane = LoadData[16*AddrLow[1] +: 16].
  - LB and LH sign-extend to DATA_W; LBU and LHU zero-extend; LW passes LoadData unchanged.
  - For DATA_W=64, only the low 32 bits are laned; LW sign-extends bit 31.
- Source select: MemReg picks ALU, aligned load, PCLink or HiLo.
- Write enable is the AND of:
  - RegWrite_MEM,
  - the instruction is captured and not a bubble,
  - WriteReg_MEM != 0,
  - not misaligned.
- A misaligned halfword load suppresses the write and pulses Misalign_WB for one cycle.
- RetireCnt increments on every edge where RegWrite_WB becomes 1 for a newly captured instruction. It does not increment while Stall holds the same instruction. It wraps from all-ones to 0 with no flag.

Optional Feature:
- Macro WB_HISTORY_EN.
- When defined: adds outputs PrevWriteValid, PrevWriteReg[REG_AW] and PrevWriteData[DATA_W]. These form a one-deep history of the last committed write, updated whenever a new write commits and held otherwise; reset value is 0. This lets ID forward data one cycle older than WB, for register files without write-before-read.
- When undefined: the ports do not exist and no history registers are built.

Decomposition:
- Shared package mips_pkg holds:
  - LoadType encodings: LT_LW, LT_LB, LT_LBU, LT_LH, LT_LHU.
  - MemReg encodings: WB_SEL_ALU, WB_SEL_LOAD, WB_SEL_LINK, WB_SEL_HILO.
  - Width defaults.
- One natural combinational sub-module: load_align (LoadData, AddrLow, LoadType -> aligned data, misalign flag). It is reused by a future cache bypass.

Test Plan:
- Rst pulsed mid-cycle while RegWrite_WB=1 -> all outputs 0 immediately, without waiting for Clk; RetireCnt=0.
- LB with LoadData=0x1234_80FF, AddrLow=1, MemReg=1, WriteReg=8 -> next cycle WriteData_WB=0xFFFF_FF80, RegWrite_WB=1. Same stimulus with LBU -> 0x0000_0080.
- LH with AddrLow=2 and LoadData=0x8001_0000 -> 0xFFFF_8001. LHU with AddrLow=3 -> RegWrite_WB=0, Misalign_WB=1 for exactly one cycle.
- MemReg=2, PCLink=0x0040_0008, WriteReg=31 -> WriteData_WB=0x0040_0008. Same with WriteReg=0 -> RegWrite_WB=0 and RetireCnt unchanged.
- Valid write, then Stall held for 3 cycles, then Flush on the next instruction -> outputs held for 3 cycles, RetireCnt +1 only, then RegWrite_WB=0.
- RetireCnt preloaded to 0xFFFF via 65535 writes, then one more write -> RetireCnt=0.
- With WB_HISTORY_EN: writes to r3 then r4 -> PrevWriteReg=3 while WriteReg_WB=4.
